// File: rtl/mips_mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, datapath
// select codes, trap causes and the opcodes the controller dispatches on.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_BRANCH   = 4'd9,
        S_IMM_EX   = 4'd10,
        S_IMM_WB   = 4'd11,
        S_JUMP     = 4'd12,
        S_TRAP     = 4'd13
    } state_e;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_FUNCT = 3'b111;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // States that sit on the memory handshake and are covered by the timeout.
    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_mem_wait_timer.sv
// Counts stalled cycles of a memory access and flags a timeout when the
// MEM_TIMEOUT-th consecutive stall cycle occurs (MEM_TIMEOUT = 0 disables it).
module mips_mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic active_i,
    input  logic mem_ready_i,
    output logic timeout_o
);
    localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = (MEM_TIMEOUT == 0) ? '0 : CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    // Clearing whenever no access is pending or one completes means the count
    // is always zero on entry to the next wait state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else if (!active_i || mem_ready_i)
            cnt_q <= '0;
        else if (cnt_q != LIMIT)
            cnt_q <= cnt_q + CW'(1);
    end

    assign timeout_o = (MEM_TIMEOUT != 0) && active_i && !mem_ready_i && (cnt_q == LIMIT);

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM. Outputs are decoded from the current state.
// Optional build macro MIPS_MC_PERF_EN adds cycle_count/retire_count outputs.
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned PERF_W      = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ext_sel,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [3:0]  state
`ifdef MIPS_MC_PERF_EN
    ,
    output logic [PERF_W-1:0] cycle_count,
    output logic [PERF_W-1:0] retire_count
`endif
);
    if (PERF_W < 1) begin : g_perf_w_chk
        $error("PERF_W must be at least 1");
    end

    state_e     state_q;
    logic [1:0] cause_q;
    logic       timeout;

    // funct is decoded by the ALU control, not here.
    logic unused_funct;
    assign unused_funct = ^funct;

    mips_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
        .clk        (clk),
        .reset_n    (reset_n),
        .active_i   (is_wait_state(state_q)),
        .mem_ready_i(mem_ready),
        .timeout_o  (timeout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cause_q <= CAUSE_NONE;
        end else begin
            case (state_q)
                S_IDLE:   state_q <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) state_q <= S_DECODE;
                    else if (timeout) begin
                        state_q <= S_TRAP;
                        cause_q <= CAUSE_TIMEOUT;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:        state_q <= S_RTYPE_EX;
                        OP_LW, OP_SW:    state_q <= S_MEMADR;
                        OP_BEQ, OP_BNE:  state_q <= S_BRANCH;
                        OP_ADDI, OP_ORI: state_q <= S_IMM_EX;
                        OP_J:            state_q <= S_JUMP;
                        default: begin
                            state_q <= S_TRAP;
                            cause_q <= CAUSE_ILLEGAL;
                        end
                    endcase
                end
                S_MEMADR: state_q <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD, S_MEMWR: begin
                    if (mem_ready) state_q <= (state_q == S_MEMRD) ? S_MEMWB : S_FETCH;
                    else if (timeout) begin
                        state_q <= S_TRAP;
                        cause_q <= CAUSE_TIMEOUT;
                    end
                end
                S_RTYPE_EX: state_q <= S_RTYPE_WB;
                S_IMM_EX:   state_q <= S_IMM_WB;
                S_MEMWB, S_RTYPE_WB, S_BRANCH, S_IMM_WB, S_JUMP: state_q <= S_FETCH;
                S_TRAP:     state_q <= S_TRAP;
                default:    state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ext_sel    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_ADD;
        pc_src     = PC_ALU;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            S_DECODE: alu_src_b = SRCB_IMM_SH;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_RTYPE_EX: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_RTYPE_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_ALUOUT;
                pc_write  = ((opcode == OP_BEQ) && alu_zero) || ((opcode == OP_BNE) && !alu_zero);
            end
            S_IMM_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if (opcode == OP_ORI) begin
                    alu_op  = ALU_OR;
                    ext_sel = 1'b1;
                end
            end
            S_IMM_WB: reg_write = 1'b1;
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_JUMP;
            end
            default: ;
        endcase
    end

    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;
    assign state      = state_q;

`ifdef MIPS_MC_PERF_EN
    logic [PERF_W-1:0] cyc_q, ret_q;
    logic              retire;

    // A store retires only when its write handshake completes.
    assign retire = (state_q inside {S_MEMWB, S_RTYPE_WB, S_BRANCH, S_IMM_WB, S_JUMP})
                 || ((state_q == S_MEMWR) && mem_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if (state_q != S_IDLE && state_q != S_TRAP) cyc_q <= cyc_q + PERF_W'(1);
            if (retire) ret_q <= ret_q + PERF_W'(1);
        end
    end

    assign cycle_count  = cyc_q;
    assign retire_count = ret_q;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: expected states queued per clock and
// popped on the following sample, plus per-state output checks.
module tb_mips_mc_ctrl;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h20;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, iord, mem_read, mem_write, ext_sel, alu_src_a;
    logic [1:0] alu_src_b, pc_src, trap_cause;
    logic [2:0] alu_op;
    logic       reg_write, reg_dst, mem_to_reg, trap;
    logic [3:0] state;
`ifdef MIPS_MC_PERF_EN
    logic [31:0] cycle_count, retire_count;
`endif

    always #5 clk = ~clk;

    mips_mc_ctrl #(.MEM_TIMEOUT(4), .PERF_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ext_sel(ext_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .trap(trap), .trap_cause(trap_cause), .state(state)
`ifdef MIPS_MC_PERF_EN
        , .cycle_count(cycle_count), .retire_count(retire_count)
`endif
    );

    logic [19:0] outs;
    assign outs = {pc_write, ir_write, iord, mem_read, mem_write, ext_sel, alu_src_a,
                   alu_src_b, alu_op, pc_src, reg_write, reg_dst, mem_to_reg, trap, trap_cause};

    int checks = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue the state expected after the next edge, then compare on the sample.
    task automatic step(input logic [3:0] st);
        logic [3:0] e;
        exp_q.push_back(st);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("state", 32'(state), 32'(e));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_async_state", 32'(state), 32'(S_IDLE));
        chk("rst_async_outs", 32'(outs), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #2;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_outs", 32'(outs), 32'd0);
        reset_n = 1'b1; mem_ready = 1'b1; opcode = OP_RTYPE;

        // R-type
        step(S_FETCH);
        chk("fetch_pcw", 32'(pc_write), 1);
        chk("fetch_irw", 32'(ir_write), 1);
        chk("fetch_mrd", 32'(mem_read), 1);
        chk("fetch_srcb", 32'(alu_src_b), 1);
        step(S_DECODE);
        chk("dec_srcb", 32'(alu_src_b), 3);
        chk("dec_pcw", 32'(pc_write), 0);
        step(S_RTYPE_EX);
        chk("rex_aluop", 32'(alu_op), 7);
        chk("rex_regw", 32'(reg_write), 0);
        step(S_RTYPE_WB);
        chk("rwb_regw", 32'(reg_write), 1);
        chk("rwb_dst", 32'(reg_dst), 1);
        step(S_FETCH);
        chk("fetch_regw", 32'(reg_write), 0);

        // lw with three stall cycles; the 4th cycle hits the limit with ready
        opcode = OP_LW;
        step(S_DECODE);
        step(S_MEMADR);
        chk("madr_srca", 32'(alu_src_a), 1);
        chk("madr_srcb", 32'(alu_src_b), 2);
        mem_ready = 1'b0;
        step(S_MEMRD);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                mem_ready = 1'b1;
                #1;
            end
            chk("lw_mrd", 32'(mem_read), 1);
            chk("lw_iord", 32'(iord), 1);
            step((i == 3) ? S_MEMWB : S_MEMRD);
        end
        chk("mwb_regw", 32'(reg_write), 1);
        chk("mwb_m2r", 32'(mem_to_reg), 1);
        chk("mwb_dst", 32'(reg_dst), 0);
        step(S_FETCH);

        // Fetch stall holds PC/IR
        mem_ready = 1'b0;
        #1;
        chk("stall_pcw", 32'(pc_write), 0);
        chk("stall_irw", 32'(ir_write), 0);
        step(S_FETCH);
        mem_ready = 1'b1;

        // beq taken
        opcode = OP_BEQ; alu_zero = 1'b1;
        step(S_DECODE);
        step(S_BRANCH);
        chk("beq_pcw", 32'(pc_write), 1);
        chk("beq_pcsrc", 32'(pc_src), 1);
        chk("beq_aluop", 32'(alu_op), 1);
        step(S_FETCH);

        // bne not taken, then taken
        opcode = OP_BNE;
        step(S_DECODE);
        step(S_BRANCH);
        chk("bne_z_pcw", 32'(pc_write), 0);
        alu_zero = 1'b0;
        #1;
        chk("bne_nz_pcw", 32'(pc_write), 1);
        step(S_FETCH);

        // ori / addi
        opcode = OP_ORI;
        step(S_DECODE);
        step(S_IMM_EX);
        chk("ori_ext", 32'(ext_sel), 1);
        chk("ori_aluop", 32'(alu_op), 2);
        chk("ori_srcb", 32'(alu_src_b), 2);
        step(S_IMM_WB);
        chk("iwb_regw", 32'(reg_write), 1);
        chk("iwb_dst", 32'(reg_dst), 0);
        step(S_FETCH);
        opcode = OP_ADDI;
        step(S_DECODE);
        step(S_IMM_EX);
        chk("addi_ext", 32'(ext_sel), 0);
        chk("addi_aluop", 32'(alu_op), 0);
        step(S_IMM_WB);
        step(S_FETCH);

        // jump
        opcode = OP_J;
        step(S_DECODE);
        step(S_JUMP);
        chk("j_pcw", 32'(pc_write), 1);
        chk("j_pcsrc", 32'(pc_src), 2);
        step(S_FETCH);

        // sw aborted by reset mid-write
        opcode = OP_SW;
        step(S_DECODE);
        step(S_MEMADR);
        mem_ready = 1'b0;
        step(S_MEMWR);
        chk("sw_mwr", 32'(mem_write), 1);
        chk("sw_iord", 32'(iord), 1);
        step(S_MEMWR);
        #2;
        do_reset();

        // Fetch timeout after four stall cycles
        step(S_FETCH);
        repeat (3) step(S_FETCH);
        step(S_TRAP);
        chk("tmo_outs", 32'(outs), 32'h6);
        mem_ready = 1'b1;
        step(S_TRAP);
        chk("tmo_hold_outs", 32'(outs), 32'h6);

        // Illegal opcode
        do_reset();
        opcode = 6'h3F;
        step(S_FETCH);
        step(S_DECODE);
        step(S_TRAP);
        chk("ill_outs", 32'(outs), 32'h5);
        repeat (3) step(S_TRAP);
        chk("ill_hold_outs", 32'(outs), 32'h5);

        // Three retired instructions
        do_reset();
        opcode = OP_RTYPE; alu_zero = 1'b0;
        step(S_FETCH);
        step(S_DECODE);
        step(S_RTYPE_EX);
        step(S_RTYPE_WB);
        step(S_FETCH);
        opcode = OP_BEQ;
        step(S_DECODE);
        step(S_BRANCH);
        chk("beq_nt_pcw", 32'(pc_write), 0);
        step(S_FETCH);
        opcode = OP_J;
        step(S_DECODE);
        step(S_JUMP);
        step(S_FETCH);
`ifdef MIPS_MC_PERF_EN
        chk("retire_count", retire_count, 3);
        chk("cycle_count", cycle_count, 10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
